// File: rtl/mips_regfile_dual.sv
// Dual-write, dual-read register file with optional write-to-read bypass,
// optional hardwired-zero register 0 and a per-register busy scoreboard.
module mips_regfile_dual #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 3,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] read_reg1,
    input  logic [ADDR_BITS-1:0] read_reg2,
    output logic [WIDTH-1:0]     read_data1,
    output logic [WIDTH-1:0]     read_data2,
    output logic                 busy1,
    output logic                 busy2,
    input  logic [ADDR_BITS-1:0] write_reg0,
    input  logic [WIDTH-1:0]     write_data0,
    input  logic                 reg_write0,
    input  logic [ADDR_BITS-1:0] write_reg1,
    input  logic [WIDTH-1:0]     write_data1,
    input  logic                 reg_write1,
    input  logic                 mark_busy,
    input  logic [ADDR_BITS-1:0] mark_reg
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy_q;

    // Register array and busy scoreboard: port 1 wins a same-address write,
    // a mark wins over a retiring write for the busy bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                if (!(ZERO_REG != 0 && r == 0)) begin
                    if (reg_write1 && write_reg1 == ADDR_BITS'(r)) begin
                        regs[r] <= write_data1;
                    end else if (reg_write0 && write_reg0 == ADDR_BITS'(r)) begin
                        regs[r] <= write_data0;
                    end

                    if (mark_busy && mark_reg == ADDR_BITS'(r)) begin
                        busy_q[r] <= 1'b1;
                    end else if ((reg_write0 && write_reg0 == ADDR_BITS'(r)) ||
                                 (reg_write1 && write_reg1 == ADDR_BITS'(r))) begin
                        busy_q[r] <= 1'b0;
                    end
                end
            end
        end
    end

    // Read port 1: array value, overridden by bypass (port 1 over port 0),
    // forced to zero for hardwired register 0 or during reset.
    always_comb begin
        read_data1 = regs[read_reg1];
        if (BYPASS != 0) begin
            if (reg_write0 && write_reg0 == read_reg1) read_data1 = write_data0;
            if (reg_write1 && write_reg1 == read_reg1) read_data1 = write_data1;
        end
        if (reset || (ZERO_REG != 0 && read_reg1 == '0)) read_data1 = '0;
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        read_data2 = regs[read_reg2];
        if (BYPASS != 0) begin
            if (reg_write0 && write_reg0 == read_reg2) read_data2 = write_data0;
            if (reg_write1 && write_reg1 == read_reg2) read_data2 = write_data1;
        end
        if (reset || (ZERO_REG != 0 && read_reg2 == '0)) read_data2 = '0;
    end

    // Busy outputs come straight from the registered scoreboard (no bypass).
    always_comb begin
        busy1 = reset ? 1'b0 : busy_q[read_reg1];
        busy2 = reset ? 1'b0 : busy_q[read_reg2];
    end

endmodule

// File: tb/tb_mips_regfile_dual.sv
// Self-checking bench for mips_regfile_dual: three parameter configurations
// driven in parallel and compared against a behavioural model.
module tb_mips_regfile_dual;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  read_reg1, read_reg2, write_reg0, write_reg1, mark_reg;
    logic [31:0] write_data0, write_data1;
    logic        reg_write0, reg_write1, mark_busy;

    // cfg 0: ZERO_REG=1 BYPASS=1, cfg 1: ZERO_REG=1 BYPASS=0, cfg 2: ZERO_REG=0 BYPASS=1
    logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1, rd1_2, rd2_2;
    logic        b1_0, b2_0, b1_1, b2_1, b1_2, b2_2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m  [3][8];
    logic        mb [3][8];

    always #5 clk = ~clk;

    mips_regfile_dual #(.WIDTH(32), .ADDR_BITS(3), .ZERO_REG(1), .BYPASS(1)) u_def (
        .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_0), .read_data2(rd2_0), .busy1(b1_0), .busy2(b2_0),
        .write_reg0(write_reg0), .write_data0(write_data0), .reg_write0(reg_write0),
        .write_reg1(write_reg1), .write_data1(write_data1), .reg_write1(reg_write1),
        .mark_busy(mark_busy), .mark_reg(mark_reg));

    mips_regfile_dual #(.WIDTH(32), .ADDR_BITS(3), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
        .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_1), .read_data2(rd2_1), .busy1(b1_1), .busy2(b2_1),
        .write_reg0(write_reg0), .write_data0(write_data0), .reg_write0(reg_write0),
        .write_reg1(write_reg1), .write_data1(write_data1), .reg_write1(reg_write1),
        .mark_busy(mark_busy), .mark_reg(mark_reg));

    mips_regfile_dual #(.WIDTH(32), .ADDR_BITS(3), .ZERO_REG(0), .BYPASS(1)) u_nozero (
        .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_2), .read_data2(rd2_2), .busy1(b1_2), .busy2(b2_2),
        .write_reg0(write_reg0), .write_data0(write_data0), .reg_write0(reg_write0),
        .write_reg1(write_reg1), .write_data1(write_data1), .reg_write1(reg_write1),
        .mark_busy(mark_busy), .mark_reg(mark_reg));

    function automatic bit zr(input int c);
        return c != 2;
    endfunction

    function automatic bit bp(input int c);
        return c != 1;
    endfunction

    function automatic logic [31:0] exp_read(input int c, input logic [2:0] a);
        if (reset) return 32'h0;
        if (zr(c) && a == 3'd0) return 32'h0;
        if (bp(c) && reg_write1 && write_reg1 == a) return write_data1;
        if (bp(c) && reg_write0 && write_reg0 == a) return write_data0;
        return m[c][a];
    endfunction

    function automatic logic exp_busy(input int c, input logic [2:0] a);
        if (reset) return 1'b0;
        if (zr(c) && a == 3'd0) return 1'b0;
        return mb[c][a];
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < 8; a++) begin
                m[c][a]  = 32'h0;
                mb[c][a] = 1'b0;
            end
    endtask

    // Effect of one rising edge: port 0 then port 1 (later write wins),
    // write-clears applied before marks (mark wins).
    task automatic model_edge();
        for (int c = 0; c < 3; c++) begin
            if (reg_write0 && !(zr(c) && write_reg0 == 3'd0)) begin
                m[c][write_reg0]  = write_data0;
                mb[c][write_reg0] = 1'b0;
            end
            if (reg_write1 && !(zr(c) && write_reg1 == 3'd0)) begin
                m[c][write_reg1]  = write_data1;
                mb[c][write_reg1] = 1'b0;
            end
            if (mark_busy && !(zr(c) && mark_reg == 3'd0))
                mb[c][mark_reg] = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("def_rd1",   rd1_0, exp_read(0, read_reg1));
        chk("def_rd2",   rd2_0, exp_read(0, read_reg2));
        chk("def_b1",    32'(b1_0), 32'(exp_busy(0, read_reg1)));
        chk("def_b2",    32'(b2_0), 32'(exp_busy(0, read_reg2)));
        chk("nobyp_rd1", rd1_1, exp_read(1, read_reg1));
        chk("nobyp_rd2", rd2_1, exp_read(1, read_reg2));
        chk("nobyp_b1",  32'(b1_1), 32'(exp_busy(1, read_reg1)));
        chk("nobyp_b2",  32'(b2_1), 32'(exp_busy(1, read_reg2)));
        chk("nozero_rd1", rd1_2, exp_read(2, read_reg1));
        chk("nozero_rd2", rd2_2, exp_read(2, read_reg2));
        chk("nozero_b1",  32'(b1_2), 32'(exp_busy(2, read_reg1)));
        chk("nozero_b2",  32'(b2_2), 32'(exp_busy(2, read_reg2)));
    endtask

    // Drive one cycle at edge+1, check at edge+3, then take the edge.
    task automatic apply(input logic rst,
                         input logic we0, input logic [2:0] wa0, input logic [31:0] wd0,
                         input logic we1, input logic [2:0] wa1, input logic [31:0] wd1,
                         input logic mk, input logic [2:0] ma,
                         input logic [2:0] ra1, input logic [2:0] ra2);
        reset = rst;
        reg_write0 = we0; write_reg0 = wa0; write_data0 = wd0;
        reg_write1 = we1; write_reg1 = wa1; write_data1 = wd1;
        mark_busy = mk; mark_reg = ma;
        read_reg1 = ra1; read_reg2 = ra2;
        if (rst) model_clear();
        #2;
        check_all();
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic idle_read(input logic [2:0] ra1, input logic [2:0] ra2);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, ra1, ra2);
    endtask

    initial begin
        model_clear();
        // Reset: all addresses read 0 and not busy
        for (int a = 0; a < 8; a += 2) begin
            apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'(a), 3'(a + 1));
            edge_step();
        end

        // Dual write to distinct registers in one edge
        apply(0, 1, 3'd4, 32'hFFFFFFFF, 1, 3'd5, 32'hFFFFFFFE, 0, 0, 3'd1, 3'd2);
        edge_step();
        idle_read(3'd4, 3'd5);
        chk("dual_r4", rd1_0, 32'hFFFFFFFF);
        chk("dual_r5", rd2_0, 32'hFFFFFFFE);
        edge_step();

        // Same-address collision: port 1 wins
        apply(0, 1, 3'd7, 32'h11111111, 1, 3'd7, 32'h22222222, 0, 0, 3'd7, 3'd7);
        chk("bypass_prio", rd1_0, 32'h22222222);
        edge_step();
        idle_read(3'd7, 3'd4);
        chk("collide_r7", rd1_0, 32'h22222222);
        chk("collide_nobyp", rd1_1, 32'h22222222);
        edge_step();

        // Bypass vs no bypass before the edge
        apply(0, 1, 3'd3, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 3'd3, 3'd3);
        chk("byp_on", rd1_0, 32'hA5A5A5A5);
        chk("byp_off", rd1_1, 32'h00000000);
        edge_step();
        idle_read(3'd3, 3'd0);
        chk("byp_off_after", rd1_1, 32'hA5A5A5A5);
        edge_step();

        // Register 0 write plus mark
        apply(0, 1, 3'd0, 32'hDEADBEEF, 0, 0, 0, 1, 3'd0, 3'd0, 3'd0);
        chk("zero_byp", rd1_0, 32'h0);
        edge_step();
        idle_read(3'd0, 3'd0);
        chk("zero_rd", rd1_0, 32'h0);
        chk("zero_busy", 32'(b1_0), 32'h0);
        chk("nozero_rd", rd1_2, 32'hDEADBEEF);
        chk("nozero_busy", 32'(b1_2), 32'h1);
        edge_step();

        // Scoreboard sequence
        apply(0, 0, 0, 0, 0, 0, 0, 1, 3'd2, 3'd2, 3'd6);
        edge_step();
        idle_read(3'd2, 3'd6);
        chk("sb_mark", 32'(b1_0), 32'h1);
        edge_step();
        apply(0, 1, 3'd2, 32'h00000099, 0, 0, 0, 0, 0, 3'd2, 3'd6);
        chk("sb_busy_same_cycle", 32'(b1_0), 32'h1);
        edge_step();
        idle_read(3'd2, 3'd6);
        chk("sb_cleared", 32'(b1_0), 32'h0);
        edge_step();
        apply(0, 0, 0, 0, 1, 3'd6, 32'h00000042, 1, 3'd6, 3'd2, 3'd6);
        edge_step();
        idle_read(3'd6, 3'd6);
        chk("sb_mark_wins", 32'(b1_0), 32'h1);
        chk("sb_data", rd1_0, 32'h00000042);
        edge_step();

        // Async reset after writes: reads drop to 0 before any edge
        apply(1, 1, 3'd5, 32'h12345678, 0, 0, 0, 1, 3'd5, 3'd4, 3'd6);
        chk("rst_async_r4", rd1_0, 32'h0);
        edge_step();
        idle_read(3'd5, 3'd6);
        chk("rst_lost_write", rd1_0, 32'h0);
        chk("rst_lost_mark", 32'(b1_0), 32'h0);
        edge_step();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 39) == 0),
                  1'($urandom), 3'($urandom), $urandom,
                  1'($urandom), 3'($urandom), $urandom,
                  ($urandom_range(0, 3) == 0), 3'($urandom),
                  3'($urandom), 3'($urandom));
            edge_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_regfile_dual.md
Name: mips_regfile_dual

Overview:
- Parametrised successor to the 8x32 MIPS register file: depth and width are generics.
- Two synchronous write ports with a fixed conflict priority, two asynchronous read ports, optional write-to-read bypass, optional hardwired-zero register 0.
- Per-register busy scoreboard so the datapath can stall on pending results.
- Sits between decode and the ALU/writeback stages of the multi-issue MIPS datapath.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_BITS, 3, register address width; depth = 2**ADDR_BITS.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all registers and busy bits.
- read_reg1  input  ADDR_BITS  read port 1 address.
- read_reg2  input  ADDR_BITS  read port 2 address.
- read_data1  output  WIDTH  read port 1 data.
- read_data2  output  WIDTH  read port 2 data.
- busy1  output  1  busy bit of read_reg1.
- busy2  output  1  busy bit of read_reg2.
- write_reg0  input  ADDR_BITS  write port 0 address.
- write_data0  input  WIDTH  write port 0 data.
- reg_write0  input  1  write port 0 enable.
- write_reg1  input  ADDR_BITS  write port 1 address.
- write_data1  input  WIDTH  write port 1 data.
- reg_write1  input  1  write port 1 enable.
- mark_busy  input  1  set the busy bit of mark_reg at the next edge.
- mark_reg  input  ADDR_BITS  register to mark busy.

Behaviour:
- Reset (async, active-high): every register = 0; every busy bit = 0.
  - read_data1/2 and busy1/2 evaluate to 0 while reset is high, independent of clk.
- Reads are combinational from the array (zero-cycle latency).
  - BYPASS=1, reg_writeN=1, write_regN==read_regK: read_dataK = write_dataN in the same cycle.
  - Port 1 bypass has priority over port 0.
  - ZERO_REG=1, address 0: read_data = 0 regardless of bypass.
- Writes occur on the rising edge of clk when reg_writeN=1.
  - Both ports enabled with equal addresses: port 1 data is stored, port 0 is dropped.
  - Different addresses: both are stored in the same edge.
- Writes to register 0 are ignored when ZERO_REG=1; when ZERO_REG=0, register 0 is an ordinary register.
- Busy scoreboard, evaluated per register at each rising edge:
  - mark_busy=1 and mark_reg==r: busy[r] <= 1. This has priority over a write to r in the same edge: a new producer supersedes the retiring one. The write data is still stored.
  - Otherwise, any enabled write port to r: busy[r] <= 0.
  - Otherwise: busy[r] holds.
  - ZERO_REG=1: busy[0] is held at 0 and mark_busy to 0 is ignored.
- busy1/busy2 reflect the registered busy bits only, with no bypass: a write clearing the bit becomes visible the cycle after the edge.
- Reset asserted mid-operation: state clears immediately. Writes and marks presented in the reset cycle are lost. Normal operation resumes at the first edge after reset deasserts.
- Out-of-range addresses cannot occur: depth is exactly 2**ADDR_BITS.

Test Plan:
- Reset with defaults -> read_data1/2 = 0 and busy1/2 = 0 for all addresses 0..7. Reassert reset after writes -> all reads return to 0 asynchronously.
- Port 0 writes reg 4 = 32'hFFFFFFFF; port 1 writes reg 5 = 32'hFFFFFFFE in the same edge -> next cycle read_reg1=4 gives FFFFFFFF and read_reg2=5 gives FFFFFFFE.
- Both ports target reg 7 with 32'h11111111 (port 0) and 32'h22222222 (port 1) -> reg 7 reads 22222222.
- BYPASS=1: write reg 3 = 32'hA5A5A5A5 while read_reg1=3 -> read_data1 = A5A5A5A5 before the edge. Repeat with BYPASS=0 -> read_data1 holds the old value until after the edge.
- ZERO_REG=1: write reg 0 = 32'hDEADBEEF and mark_busy reg 0 -> read_data = 0, busy = 0. With ZERO_REG=0 -> reads DEADBEEF.
- Scoreboard sequence:
  - mark reg 2 -> busy1=1 next cycle.
  - Write reg 2 -> busy1=0 the cycle after the edge.
  - Same-edge mark reg 6 plus write reg 6 = 32'h00000042 -> busy=1 and data=42.
